emulador_dht11: RTL and testbench
=================================

EMULADOR_DHT11 -- requirements
Module: emulador_dht11

Interface
REQ-001 Parameter CICLOS_US, default 50: clock cycles per microsecond (50 MHz board clock).
REQ-002 Parameter MIN_INICIO_US, default 18000: minimum host low pulse, in microseconds, accepted as a start request.
REQ-003 Port clock, input, 1: single system clock; all logic rising-edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port habilita, input, 1: 1 = emulator answers start requests; 0 = requests ignored, bus never driven.
REQ-006 Port umidade, input, 16: humidity to report, {integer byte, decimal byte}.
REQ-007 Port temperatura, input, 16: temperature to report, {integer byte, decimal byte}.
REQ-008 Port dht_bus, inout, 1: open-drain single-wire bus; driven only to 0, otherwise high-Z.
REQ-009 Port ocupado, output, 1: high from start acceptance until frame end.
REQ-010 Port pronto, output, 1: one-cycle pulse when the bus is released after the final bit.
REQ-011 Port db_estado, output, 4: current FSM state encoding.

Function
REQ-012 dht_bus input SHALL pass through a 2-flop synchronizer before any use; the FSM never samples the raw pin.
REQ-013 The bus SHALL be driven low only in states RESP_BAIXO, BIT_BAIXO and FIM_BAIXO; high-Z in all other states.
REQ-014 States: OCIOSO, INICIO_BAIXO, ESPERA_HOST, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO, FIM_BAIXO, FIM.
REQ-015 OCIOSO -> INICIO_BAIXO when the synchronized bus is 0 and habilita=1; the duration counter clears on entry.
REQ-016 INICIO_BAIXO: if the bus returns to 1 before MIN_INICIO_US*CICLOS_US cycles, return to OCIOSO (glitch); if the bus returns to 1 after the count is reached, go to ESPERA_HOST.
REQ-017 On INICIO_BAIXO -> ESPERA_HOST, the frame register SHALL latch {umidade, temperatura, checksum}, 40 bits, where checksum = sum of the four bytes mod 256; input changes after that edge do not affect the frame.
REQ-018 On the same edge, ocupado SHALL rise.
REQ-019 ESPERA_HOST: 30 us, bus released, then RESP_BAIXO.
REQ-020 RESP_BAIXO: drive low 80 us, then RESP_ALTO.
REQ-021 RESP_ALTO: release 80 us, then BIT_BAIXO with bit index 39.
REQ-022 BIT_BAIXO: drive low 50 us, then BIT_ALTO.
REQ-023 BIT_ALTO: release 26 us if frame[index]=0, 70 us if 1.
REQ-024 Exit from BIT_ALTO: if index=0, go to FIM_BAIXO; otherwise decrement index and go to BIT_BAIXO. Transmission is MSB first.
REQ-025 FIM_BAIXO: drive low 50 us, then FIM.
REQ-026 FIM: release the bus, pulse pronto for one cycle, clear ocupado, return to OCIOSO next cycle.
REQ-027 Each timed state SHALL last exactly N*CICLOS_US clock cycles, with its counter cleared on state entry.
REQ-028 All counters SHALL be sized with $clog2 of their maximum count and never wrap within a state.
REQ-029 habilita falling while ocupado=1 SHALL NOT abort the frame; the current frame completes.
REQ-030 A bus low observed during RESP_ALTO or BIT_ALTO (contention) SHALL be ignored; timing continues unchanged.

Reset
REQ-031 While reset=1 at a clock edge: state = OCIOSO, bus high-Z, ocupado=0, pronto=0, all counters and the bit index cleared, synchronizer flops set to 1.
REQ-032 Reset asserted mid-frame SHALL release the bus on the next clock edge; no partial frame resumes after reset.

Configuration
REQ-033 Macro DHT11_ERRO_CHECKSUM_EN: when defined, add input injeta_erro, 1 bit, sampled at the latch edge of REQ-017; if injeta_erro=1, checksum bit 0 is inverted.
REQ-034 When DHT11_ERRO_CHECKSUM_EN is undefined, the injeta_erro port is absent and the checksum is always correct.

Verification (CICLOS_US=1, MIN_INICIO_US=18)
REQ-035 Normal frame: umidade=16'h3700, temperatura=16'h1905; host low 20 cycles, then release -> low 80, high 80, then 40 bits with checksum 8'h55 (01010101); pronto pulses once; ocupado spans the frame.
REQ-036 Glitch rejection: host low 10 cycles, then release -> bus never driven, ocupado stays 0, state returns to OCIOSO.
REQ-037 Bit timing: temperatura=16'hFFFF, umidade=16'h0000 -> first 16 bit-high periods are 26 cycles, the next 16 are 70 cycles.
REQ-038 Reset mid-frame: reset asserted during BIT_ALTO of bit 20 -> bus high-Z next edge, ocupado=0, pronto never pulses; a new 20-cycle start then yields a complete frame.
REQ-039 habilita=0 with a 20-cycle host low -> no response; habilita dropped mid-frame -> the frame still completes.
REQ-040 With DHT11_ERRO_CHECKSUM_EN defined and injeta_erro=1 using the REQ-035 data -> transmitted checksum is 8'h54.

Source files
------------

// File: rtl/emulador_dht11.sv
// emulador_dht11: DHT11 sensor emulator on an open-drain bus; define DHT11_ERRO_CHECKSUM_EN to add injeta_erro checksum fault injection
module emulador_dht11 #(
    parameter int CICLOS_US     = 50,
    parameter int MIN_INICIO_US = 18000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic [15:0] umidade,
    input  logic [15:0] temperatura,
`ifdef DHT11_ERRO_CHECKSUM_EN
    input  logic        injeta_erro,
`endif
    inout  wire         dht_bus,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);
    typedef enum logic [3:0] {
        OCIOSO, INICIO_BAIXO, ESPERA_HOST, RESP_BAIXO, RESP_ALTO,
        BIT_BAIXO, BIT_ALTO, FIM_BAIXO, FIM
    } estado_t;

    localparam int LIM_INI = MIN_INICIO_US * CICLOS_US;
    localparam int CNT_MAX = LIM_INI > 80 * CICLOS_US ? LIM_INI : 80 * CICLOS_US;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] T26 = CW'(26 * CICLOS_US - 1);
    localparam logic [CW-1:0] T30 = CW'(30 * CICLOS_US - 1);
    localparam logic [CW-1:0] T50 = CW'(50 * CICLOS_US - 1);
    localparam logic [CW-1:0] T70 = CW'(70 * CICLOS_US - 1);
    localparam logic [CW-1:0] T80 = CW'(80 * CICLOS_US - 1);

    estado_t       estado, prox;
    logic [1:0]    sinc;
    logic          bus_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dur;
    logic          fim_t;
    logic          ini_ok;
    logic [5:0]    idx;
    logic [39:0]   quadro;
    logic [7:0]    soma;
    logic [7:0]    chk;
    logic          baixo;

    assign bus_s  = sinc[1];
    assign soma   = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
`ifdef DHT11_ERRO_CHECKSUM_EN
    assign chk    = soma ^ {7'd0, injeta_erro};
`else
    assign chk    = soma;
`endif
    assign dur    = estado == ESPERA_HOST ? T30 :
                    (estado == RESP_BAIXO || estado == RESP_ALTO) ? T80 :
                    estado == BIT_ALTO ? (quadro[idx] ? T70 : T26) : T50;
    assign fim_t  = cnt == dur;
    assign ini_ok = cnt >= CW'(LIM_INI);
    assign db_estado = estado;
    assign dht_bus   = baixo ? 1'b0 : 1'bz;

    always_ff @(posedge clock) begin
        sinc   <= reset ? 2'b11 : {sinc[0], dht_bus};
        estado <= reset ? OCIOSO : prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:       prox = (!bus_s && habilita) ? INICIO_BAIXO : OCIOSO;
            INICIO_BAIXO: prox = bus_s ? (ini_ok ? ESPERA_HOST : OCIOSO) : INICIO_BAIXO;
            ESPERA_HOST:  prox = fim_t ? RESP_BAIXO : ESPERA_HOST;
            RESP_BAIXO:   prox = fim_t ? RESP_ALTO : RESP_BAIXO;
            RESP_ALTO:    prox = fim_t ? BIT_BAIXO : RESP_ALTO;
            BIT_BAIXO:    prox = fim_t ? BIT_ALTO : BIT_BAIXO;
            BIT_ALTO:     prox = fim_t ? (idx == 6'd0 ? FIM_BAIXO : BIT_BAIXO) : BIT_ALTO;
            FIM_BAIXO:    prox = fim_t ? FIM : FIM_BAIXO;
            FIM:          prox = OCIOSO;
            default:      prox = OCIOSO;
        endcase
    end

    always_comb begin
        baixo   = estado == RESP_BAIXO || estado == BIT_BAIXO || estado == FIM_BAIXO;
        ocupado = estado >= ESPERA_HOST && estado <= FIM_BAIXO;
        pronto  = estado == FIM;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            quadro <= '0;
        end else begin
            cnt <= (prox != estado) ? '0 : cnt + {{(CW-1){1'b0}}, cnt != CW'(CNT_MAX)};
            if (estado == RESP_ALTO && fim_t)
                idx <= 6'd39;
            else if (estado == BIT_ALTO && fim_t && idx != 6'd0)
                idx <= idx - 6'd1;
            if (estado == INICIO_BAIXO && prox == ESPERA_HOST)
                quadro <= {umidade, temperatura, chk};
        end
    end
endmodule

// File: tb/tb_emulador_dht11.sv
// tb_emulador_dht11: scoreboard bench decoding emulator frames from the bus waveform
module tb_emulador_dht11;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        habilita = 1'b1;
    logic        host_low = 1'b0;
    logic [15:0] umidade = '0;
    logic [15:0] temperatura = '0;
`ifdef DHT11_ERRO_CHECKSUM_EN
    logic        injeta_erro = 1'b0;
`endif
    wire         dht_bus;
    logic        ocupado, pronto;
    logic [3:0]  db_estado;

    typedef struct packed {
        logic [39:0] frame;
        logic        completa;
    } exp_t;

    exp_t sb[$];
    int total = 0, passed = 0, frames_done = 0, pulsos = 0;

    assign dht_bus = host_low ? 1'b0 : 1'bz;
    pullup (dht_bus);

    always #5 clock = ~clock;

    emulador_dht11 #(.CICLOS_US(1), .MIN_INICIO_US(18)) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .umidade(umidade),
        .temperatura(temperatura),
`ifdef DHT11_ERRO_CHECKSUM_EN
        .injeta_erro(injeta_erro),
`endif
        .dht_bus(dht_bus),
        .ocupado(ocupado),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    endtask

    task automatic meas(input logic lvl, output int n);
        n = 0;
        while (dht_bus === lvl && ocupado && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic start(input int n);
        @(negedge clock);
        host_low = 1'b1;
        repeat (n) @(negedge clock);
        host_low = 1'b0;
    endtask

    task automatic wait_ocupado();
        int k = 0;
        while (!ocupado && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("ocupado_sobe", ocupado, 1);
    endtask

    task automatic wait_frame(input int base);
        int k = 0;
        while (frames_done == base && k < 8000) begin
            @(negedge clock);
            k++;
        end
        chk("quadro_terminou", frames_done, base + 1);
    endtask

    always @(negedge clock) if (pronto) pulsos++;

    // Monitor: decodes every frame the DUT transmits and compares with the scoreboard
    initial begin
        exp_t e;
        int n, lo_bad, hi_bad, w_esp, w_rlo, w_rhi, w_flo;
        logic [39:0] got;
        logic done, o_fim, p_next;
        forever begin
            @(negedge clock);
            if (ocupado) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL frame_inesperado: got frame expected none");
                    e = '{frame: 40'd0, completa: 1'b1};
                end else e = sb.pop_front();
                meas(1'b1, w_esp);
                meas(1'b0, w_rlo);
                meas(1'b1, w_rhi);
                lo_bad = 0;
                hi_bad = 0;
                got = '0;
                for (int i = 39; i >= 0; i--) begin
                    meas(1'b0, n);
                    if (n != 50) lo_bad++;
                    meas(1'b1, n);
                    got[i] = n > 48;
                    if (n != (e.frame[i] ? 70 : 26)) hi_bad++;
                end
                meas(1'b0, w_flo);
                done = pronto;
                o_fim = ocupado;
                chk("completa", done, e.completa);
                if (e.completa) begin
                    @(negedge clock);
                    p_next = pronto;
                    chk("espera_w", w_esp, 30);
                    chk("resp_baixo_w", w_rlo, 80);
                    chk("resp_alto_w", w_rhi, 80);
                    chk("bit_baixo_erros", lo_bad, 0);
                    chk("bit_alto_erros", hi_bad, 0);
                    chk("quadro", got, e.frame);
                    chk("fim_baixo_w", w_flo, 50);
                    chk("ocupado_fim", o_fim, 0);
                    chk("pronto_1ciclo", p_next, 0);
                end else chk("ocupado_abortado", ocupado, 0);
                frames_done++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fd, bad, ent, k, p0;
        logic [3:0] prev;
        repeat (3) @(negedge clock);
        chk("rst_estado", db_estado, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_bus", dht_bus, 1);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        umidade = 16'h3700; temperatura = 16'h1905;
        sb.push_back('{frame: 40'h3700190555, completa: 1'b1});
        fd = frames_done;
        start(20);
        wait_ocupado();
        umidade = 16'hAAAA; temperatura = 16'h5555;
        wait_frame(fd);
        repeat (10) @(negedge clock);

        start(10);
        bad = 0;
        repeat (80) begin
            @(negedge clock);
            if (ocupado || dht_bus === 1'b0) bad++;
        end
        chk("glitch_silencio", bad, 0);
        chk("glitch_estado", db_estado, 0);

        umidade = 16'h0000; temperatura = 16'hFFFF;
        sb.push_back('{frame: 40'h0000FFFFFE, completa: 1'b1});
        fd = frames_done;
        start(20);
        wait_frame(fd);
        repeat (10) @(negedge clock);

        umidade = 16'h3700; temperatura = 16'h1905;
        sb.push_back('{frame: 40'h3700190555, completa: 1'b0});
        fd = frames_done;
        p0 = pulsos;
        start(20);
        ent = 0; k = 0; prev = db_estado;
        while (ent < 20 && k < 8000) begin
            @(negedge clock);
            k++;
            if (db_estado == 4'd6 && prev != 4'd6) ent++;
            prev = db_estado;
        end
        chk("bit20_alcancado", ent, 20);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_meio_bus", dht_bus, 1);
        chk("rst_meio_ocupado", ocupado, 0);
        chk("rst_meio_estado", db_estado, 0);
        reset = 1'b0;
        wait_frame(fd);
        repeat (10) @(negedge clock);
        chk("rst_meio_sem_pronto", pulsos, p0);
        sb.push_back('{frame: 40'h3700190555, completa: 1'b1});
        fd = frames_done;
        start(20);
        wait_frame(fd);
        repeat (10) @(negedge clock);

        habilita = 1'b0;
        start(20);
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (ocupado || dht_bus === 1'b0) bad++;
        end
        chk("desabilitado", bad, 0);

        habilita = 1'b1;
        umidade = 16'h1234; temperatura = 16'h5678;
        sb.push_back('{frame: 40'h1234567814, completa: 1'b1});
        fd = frames_done;
        start(20);
        wait_ocupado();
        repeat (200) @(negedge clock);
        habilita = 1'b0;
        wait_frame(fd);
        habilita = 1'b1;
        repeat (10) @(negedge clock);

`ifdef DHT11_ERRO_CHECKSUM_EN
        umidade = 16'h3700; temperatura = 16'h1905; injeta_erro = 1'b1;
        sb.push_back('{frame: 40'h3700190554, completa: 1'b1});
        fd = frames_done;
        start(20);
        wait_ocupado();
        injeta_erro = 1'b0;
        wait_frame(fd);
        repeat (10) @(negedge clock);
`endif

        chk("fila_vazia", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
